// File: rtl/sort_engine.sv
// -----------------------------------------------------------------------------
// sort_engine
//   Memory-side bubble-sort coprocessor. Sorts `len` words of data memory in
//   place starting at `base_addr`, ascending or descending, and reports the
//   number of swaps performed. Talks to a single-port data memory with a
//   1-cycle read latency.
//
// Ports
//   CLK         system clock (posedge)
//   rst         asynchronous active-low reset
//   start       one-cycle start pulse, honoured only in IDLE
//   base_addr   first word address (sampled on start)
//   len         number of words (sampled on start)
//   descending  0 = ascending, 1 = descending (sampled on start)
//   busy        high while a sort is in progress (low in the FIN cycle)
//   done        one-cycle completion pulse
//   swap_count  swaps performed by the last sort, saturating
//   mem_addr / mem_rd_en / mem_rdata / mem_wr_en / mem_wdata
//               data memory port; read data arrives one cycle after mem_rd_en
//
// Configuration
//   SORT_EARLY_EXIT_EN  when defined, a pass without any swap ends the sort.
//                       When undefined, len-1 passes are always run.
// -----------------------------------------------------------------------------
module sort_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              descending,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  swap_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_CMP    = 3'd3,
        S_WR_A   = 3'd4,
        S_WR_B   = 3'd5,
        S_ADV    = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    localparam logic [LEN_W-1:0]  ONE_L   = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

    // Strict compare: equal words never swap, which keeps the sort stable.
    function automatic logic f_swap(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic              desc);
        logic res;
        if (desc) begin
            res = (a < b);
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_base, w_base_nxt;
    logic                r_desc, w_desc_nxt;
    logic [LEN_W-1:0]    r_i, w_i_nxt;
    logic [LEN_W-1:0]    r_last, w_last_nxt;
    logic [DATA_W-1:0]   r_a, w_a_nxt;
    logic [DATA_W-1:0]   r_b, w_b_nxt;
    logic                r_pass_swapped, w_ps_nxt;
    logic [CNT_W-1:0]    r_swap_count, w_cnt_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_addr_nxt;
    logic                r_rd_en, w_rd_nxt;
    logic                r_wr_en, w_wr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;

    // Next-state, datapath and (pre-registered) memory-port decode.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_desc_nxt  = r_desc;
        w_i_nxt     = r_i;
        w_last_nxt  = r_last;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_ps_nxt    = r_pass_swapped;
        w_cnt_nxt   = r_swap_count;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_base_nxt = base_addr;
                    w_desc_nxt = descending;
                    w_cnt_nxt  = {CNT_W{1'b0}};
                    w_ps_nxt   = 1'b0;
                    w_i_nxt    = {LEN_W{1'b0}};
                    w_last_nxt = len - ONE_L;
                    if (len < LEN_W'(2)) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_LOAD_A;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD_A: w_state_nxt = S_LOAD_B;
            S_LOAD_B: begin
                w_a_nxt     = mem_rdata;
                w_state_nxt = S_CMP;
            end
            S_CMP: begin
                w_b_nxt = mem_rdata;
                if (f_swap(r_a, mem_rdata, r_desc)) begin
                    w_state_nxt = S_WR_A;
                end else begin
                    w_state_nxt = S_ADV;
                end
            end
            S_WR_A: w_state_nxt = S_WR_B;
            S_WR_B: begin
                if (r_swap_count != CNT_MAX) begin
                    w_cnt_nxt = r_swap_count + ONE_C;
                end else begin
                    w_cnt_nxt = r_swap_count;
                end
                w_ps_nxt    = 1'b1;
                w_state_nxt = S_ADV;
            end
            S_ADV: begin
                // i < last always holds here, so i+1 cannot overflow LEN_W.
                if ((r_i + ONE_L) < r_last) begin
                    w_i_nxt     = r_i + ONE_L;
                    w_state_nxt = S_LOAD_A;
                end else if (r_last == ONE_L) begin
                    w_state_nxt = S_FIN;
`ifdef SORT_EARLY_EXIT_EN
                end else if (!r_pass_swapped) begin
                    w_state_nxt = S_FIN;
`endif
                end else begin
                    w_last_nxt  = r_last - ONE_L;
                    w_i_nxt     = {LEN_W{1'b0}};
                    w_ps_nxt    = 1'b0;
                    w_state_nxt = S_LOAD_A;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Port values are decoded from the next state so they can be
        // registered and still line up with the state they belong to.
        w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
        w_done_nxt  = (w_state_nxt == S_FIN);
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_addr_nxt  = r_mem_addr;
        w_wdata_nxt = r_wdata;
        case (w_state_nxt)
            S_LOAD_A: begin
                w_rd_nxt   = 1'b1;
                w_addr_nxt = w_base_nxt + ADDR_W'(w_i_nxt);
            end
            S_LOAD_B: begin
                w_rd_nxt   = 1'b1;
                w_addr_nxt = r_base + ADDR_W'(r_i) + ONE_A;
            end
            S_WR_A: begin
                w_wr_nxt    = 1'b1;
                w_addr_nxt  = r_base + ADDR_W'(r_i);
                w_wdata_nxt = w_b_nxt;
            end
            S_WR_B: begin
                w_wr_nxt    = 1'b1;
                w_addr_nxt  = r_base + ADDR_W'(r_i) + ONE_A;
                w_wdata_nxt = r_a;
            end
            default: begin
                w_rd_nxt = 1'b0;
                w_wr_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, statistics and registered memory-port outputs.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_base         <= {ADDR_W{1'b0}};
            r_desc         <= 1'b0;
            r_i            <= {LEN_W{1'b0}};
            r_last         <= {LEN_W{1'b0}};
            r_a            <= {DATA_W{1'b0}};
            r_b            <= {DATA_W{1'b0}};
            r_pass_swapped <= 1'b0;
            r_swap_count   <= {CNT_W{1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_mem_addr     <= {ADDR_W{1'b0}};
            r_rd_en        <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wdata        <= {DATA_W{1'b0}};
        end else begin
            r_base         <= w_base_nxt;
            r_desc         <= w_desc_nxt;
            r_i            <= w_i_nxt;
            r_last         <= w_last_nxt;
            r_a            <= w_a_nxt;
            r_b            <= w_b_nxt;
            r_pass_swapped <= w_ps_nxt;
            r_swap_count   <= w_cnt_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_mem_addr     <= w_addr_nxt;
            r_rd_en        <= w_rd_nxt;
            r_wr_en        <= w_wr_nxt;
            r_wdata        <= w_wdata_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign swap_count = r_swap_count;
    assign mem_addr   = r_mem_addr;
    assign mem_rd_en  = r_rd_en;
    assign mem_wr_en  = r_wr_en;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_sort_engine.sv
// -----------------------------------------------------------------------------
// tb_sort_engine
//   Self-checking bench for sort_engine. A behavioural 256-word memory with
//   1-cycle read latency sits on the DUT port. For every sort the bench
//   computes the expected words, swap count and latency from its own copy of
//   the data and pushes them to scoreboard queues; they are popped and
//   compared when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_sort_engine;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [5:0]  len;
    logic        descending;
    logic        busy;
    logic        done;
    logic [15:0] swap_count;
    logic [7:0]  mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;

    sort_engine #(.DATA_W(16), .ADDR_W(8), .LEN_W(6), .CNT_W(16)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .descending (descending),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata)
    );

    always #5 CLK = ~CLK;

    // Memory model, bench preload port and activity monitors.
    logic [15:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_waddr = 8'd0;
    logic [15:0] tb_wdata = 16'd0;
    logic        tb_clr = 1'b0;
    int          win_base = 0;
    int          win_len = 256;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          bad_addr = 0;
    int          both_cnt = 0;

    always @(posedge CLK) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
        if (tb_clr) begin
            wr_cnt   <= 0;
            rd_cnt   <= 0;
            bad_addr <= 0;
        end else begin
            if (mem_wr_en) wr_cnt <= wr_cnt + 1;
            if (mem_rd_en) rd_cnt <= rd_cnt + 1;
            if ((mem_rd_en || mem_wr_en) &&
                ((((int'(mem_addr)) - win_base) & 255) >= win_len))
                bad_addr <= bad_addr + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard queues.
    int          exp_swaps [$];
    int          exp_lat   [$];
    logic [15:0] exp_words [$];
    logic [15:0] ld_q [$];

    // Preload ld_q at base (wrapping) and clear the activity monitors.
    task automatic load_words(input int base);
        foreach (ld_q[k]) begin
            @(negedge CLK);
            tb_we    = 1'b1;
            tb_clr   = 1'b1;
            tb_waddr = 8'((base + k) & 255);
            tb_wdata = ld_q[k];
        end
        @(negedge CLK);
        tb_we  = 1'b0;
        tb_clr = 1'b0;
    endtask

    task automatic clear_monitors();
        @(negedge CLK);
        tb_clr = 1'b1;
        @(negedge CLK);
        tb_clr = 1'b0;
    endtask

    // Reference: result words, inversions (= swaps) and cycle count.
    task automatic compute_expected(input int base, input int n, input bit desc);
        logic [15:0] m [64];
        logic [15:0] t;
        int inv = 0;
        int cyc_e = 1;
        bit sw;
        for (int k = 0; k < n; k++) m[k] = mem[(base + k) & 255];
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if (desc ? (m[i] < m[j]) : (m[i] > m[j])) inv++;
        for (int last = n - 1; last >= 1; last--) begin
            sw = 1'b0;
            for (int i = 0; i < last; i++) begin
                cyc_e += 4;
                if (desc ? (m[i] < m[i+1]) : (m[i] > m[i+1])) begin
                    t = m[i]; m[i] = m[i+1]; m[i+1] = t;
                    cyc_e += 2;
                    sw = 1'b1;
                end
            end
`ifdef SORT_EARLY_EXIT_EN
            if (!sw) break;
`endif
        end
        exp_swaps.push_back(inv);
        exp_lat.push_back(cyc_e);
        for (int k = 0; k < n; k++) exp_words.push_back(m[k]);
    endtask

    // Run one sort; restart_at>0 pulses a bogus start that many cycles in.
    // Latency is counted from the start cycle to the done cycle.
    task automatic run_sort(input int base, input int n, input bit desc,
                            input int restart_at, output int lat);
        int  t0;
        bit  seen;
        compute_expected(base, n, desc);
        @(negedge CLK);
        start      = 1'b1;
        base_addr  = 8'(base);
        len        = 6'(n);
        descending = desc;
        t0         = cyc;
        @(negedge CLK);
        start      = 1'b0;
        base_addr  = 8'(base + 77);
        len        = 6'd2;
        descending = ~desc;
        check_eq("busy_after_start", busy, (n >= 2) ? 1 : 0);
        seen = 1'b0;
        lat  = -1;
        for (int w = 1; w < 4000 && !seen; w++) begin
            if (done) begin
                seen = 1'b1;
                lat  = cyc - t0;
                check_eq("busy_in_fin", busy, 0);
            end else begin
                start = (w == restart_at);
                @(negedge CLK);
            end
        end
        start = 1'b0;
        check_eq("done_seen", seen, 1);
        @(negedge CLK);
        check_eq("done_single", done, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("swap_count", swap_count, exp_swaps.pop_front());
        check_eq("latency", lat, exp_lat.pop_front());
        for (int k = 0; k < n; k++)
            check_eq($sformatf("word%0d", k), mem[(base + k) & 255], exp_words.pop_front());
    endtask

    int lat;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        base_addr  = 8'd0;
        len        = 6'd0;
        descending = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rd", mem_rd_en, 0);
        check_eq("rst_wr", mem_wr_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_swaps", swap_count, 0);
        rst = 1'b1;

        // Q3 data, ascending.
        ld_q = '{16'd5, 16'd2, 16'd4, 16'd3, 16'd6, 16'd100};
        load_words(31);
        run_sort(31, 5, 1'b0, 0, lat);
        check_eq("q3_first", mem[31], 2);
        check_eq("q3_last", mem[35], 6);
        check_eq("q3_guard", mem[36], 100);
        check_eq("q3_swaps", swap_count, 4);

        // Same data, descending.
        load_words(31);
        run_sort(31, 5, 1'b1, 0, lat);
        check_eq("desc_first", mem[31], 6);
        check_eq("desc_swaps", swap_count, 6);
        check_eq("desc_guard", mem[36], 100);

        // Already sorted: no writes, fixed latency.
        ld_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        load_words(10);
        run_sort(10, 5, 1'b0, 0, lat);
        check_eq("sorted_no_wr", wr_cnt, 0);
`ifdef SORT_EARLY_EXIT_EN
        check_eq("sorted_lat", lat, 17);
`else
        check_eq("sorted_lat", lat, 41);
`endif

        // len = 0 and len = 1: no memory traffic.
        for (int n = 0; n < 2; n++) begin
            clear_monitors();
            run_sort(50, n, 1'b0, 0, lat);
            check_eq("short_strobes", rd_cnt + wr_cnt, 0);
        end

        // Address wrap-around.
        ld_q = '{16'd9, 16'd7, 16'd8, 16'd1};
        load_words(254);
        mem[2] = mem[2];
        win_base = 254;
        win_len  = 4;
        run_sort(254, 4, 1'b0, 0, lat);
        check_eq("wrap_window", bad_addr, 0);
        check_eq("wrap_lo", mem[254], 1);
        check_eq("wrap_hi", mem[1], 9);
        win_base = 0;
        win_len  = 256;

        // start pulsed mid-sort must be ignored.
        ld_q.delete();
        for (int k = 0; k < 8; k++) ld_q.push_back(16'($urandom_range(0, 7)));
        load_words(100);
        run_sort(100, 8, 1'b1, 9, lat);

        // Random sorts of varying length and direction.
        for (int r = 0; r < 3; r++) begin
            ld_q.delete();
            for (int k = 0; k < 12; k++) ld_q.push_back(16'($urandom_range(0, 65535)));
            load_words(140 + r * 20);
            run_sort(140 + r * 20, 10 + r, r[0], 0, lat);
        end

        // Asynchronous reset in the middle of a pass.
        ld_q = '{16'd8, 16'd6, 16'd7, 16'd5, 16'd4, 16'd3};
        load_words(200);
        @(negedge CLK);
        start      = 1'b1;
        base_addr  = 8'd200;
        len        = 6'd6;
        descending = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        repeat (9) @(negedge CLK);
        for (int w = 0; w < 20 && !mem_rd_en; w++) @(negedge CLK);
        check_eq("pre_rst_rd", mem_rd_en, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_rd", mem_rd_en, 0);
        check_eq("arst_wr", mem_wr_en, 0);
        check_eq("arst_swaps", swap_count, 0);
        repeat (2) @(negedge CLK);
        rst = 1'b1;

        // Fresh sort after reset.
        load_words(200);
        run_sort(200, 6, 1'b0, 0, lat);
        check_eq("fresh_first", mem[200], 3);

        check_eq("no_dual_strobe", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
